// File: rtl/spy_meas_pkg.sv
// Shared types and defaults for the spy-path delay measurement blocks.
package spy_meas_pkg;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SETTLE = 2'd2,
        REPORT = 2'd3
    } meas_state_t;

    // The accumulated sum needs room for 2^trialsLog2 counts of cntW bits each.
    function automatic int sumWidth(input int cntW, input int trialsLog2);
        return cntW + trialsLog2;
    endfunction

endpackage

// File: rtl/path_sync2.sv
// Two-flop synchronizer for the asynchronous chain output; both flops clear to 0.
module path_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/path_delay_meter.sv
// Spy-path delay meter: launches alternating edges into the chain and accumulates settle counts.
// Define PATH_DELAY_MINMAX_EN to add the delay_min/delay_max trackers.
module path_delay_meter
    import spy_meas_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TRIALS_LOG2 = 4,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SETTLE_CYC  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    output logic                                    busy,
    output logic                                    launch,
    input  logic                                    path_result,
    output logic                                    result_valid,
    input  logic                                    result_ready,
    output logic [sumWidth(CNT_W, TRIALS_LOG2)-1:0] delay_sum,
    output logic [CNT_W-1:0]                        delay_avg,
    output logic                                    timeout,
`ifdef PATH_DELAY_MINMAX_EN
    output logic [CNT_W-1:0]                        delay_min,
    output logic [CNT_W-1:0]                        delay_max,
`endif
    output logic [TRIALS_LOG2:0]                    trials_done
);

    localparam int SUM_W = sumWidth(CNT_W, TRIALS_LOG2);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [TRIALS_LOG2:0] N_TRIALS    = {1'b1, {TRIALS_LOG2{1'b0}}};
    localparam logic [CNT_W-1:0]     TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    meas_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic [SET_W-1:0]   settleCnt;
    logic               syncQ;
    logic               matched;
    logic [TRIALS_LOG2:0] trialsNext;

    path_sync2 uSync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (path_result),
        .q    (syncQ)
    );

    assign matched      = (syncQ == launch);
    assign trialsNext   = trials_done + (TRIALS_LOG2 + 1)'(1);
    assign busy         = (state != IDLE);
    assign result_valid = (state == REPORT);
    assign delay_avg    = delay_sum[SUM_W-1:TRIALS_LOG2];

    // launch is deliberately never cleared by start, so successive measurements keep alternating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            launch      <= 1'b0;
            cnt         <= '0;
            settleCnt   <= '0;
            delay_sum   <= '0;
            trials_done <= '0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        launch      <= ~launch;
                        cnt         <= '0;
                        delay_sum   <= '0;
                        trials_done <= '0;
                        timeout     <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (matched) begin
                        delay_sum   <= delay_sum + SUM_W'(cnt);
                        trials_done <= trialsNext;
                        settleCnt   <= '0;
                        state       <= (trialsNext == N_TRIALS) ? REPORT : SETTLE;
                    end else if (cnt == TIMEOUT_CNT) begin
                        timeout <= 1'b1;
                        state   <= REPORT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (settleCnt == SETTLE_LAST) begin
                        launch <= ~launch;
                        cnt    <= '0;
                        state  <= WAIT;
                    end else begin
                        settleCnt <= settleCnt + SET_W'(1);
                    end
                end
                REPORT: begin
                    if (result_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PATH_DELAY_MINMAX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_min <= '1;
            delay_max <= '0;
        end else if (state == IDLE && start) begin
            delay_min <= '1;
            delay_max <= '0;
        end else if (state == WAIT && matched) begin
            if (cnt < delay_min) delay_min <= cnt;
            if (cnt > delay_max) delay_max <= cnt;
        end
    end
`endif

endmodule

// File: tb/tb_path_delay_meter.sv
// Bench for path_delay_meter: per-direction delay-chain model, trial-level reference model.
// Min/max checks are compiled in when PATH_DELAY_MINMAX_EN is defined.
module tb_path_delay_meter;
    import spy_meas_pkg::*;

    localparam int CNT_W  = 12;
    localparam int TL     = 2;
    localparam int NT     = 1 << TL;
    localparam int TO     = 20;
    localparam int SC     = 8;
    localparam int SUM_W  = CNT_W + TL;
    localparam int ALL1   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic result_ready = 1'b0;
    logic path_result;
    logic busy, launch, result_valid, timeout;
    logic [SUM_W-1:0] delay_sum;
    logic [CNT_W-1:0] delay_avg;
    logic [TL:0]      trials_done;
`ifdef PATH_DELAY_MINMAX_EN
    logic [CNT_W-1:0] delay_min, delay_max;
`endif

    path_delay_meter #(
        .CNT_W(CNT_W), .TRIALS_LOG2(TL), .TIMEOUT(TO), .SETTLE_CYC(SC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .busy(busy),
        .launch(launch),
        .path_result(path_result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .delay_sum(delay_sum),
        .delay_avg(delay_avg),
        .timeout(timeout),
`ifdef PATH_DELAY_MINMAX_EN
        .delay_min(delay_min),
        .delay_max(delay_max),
`endif
        .trials_done(trials_done)
    );

    always #5 clk = ~clk;

    // Delay chain model: a flop line on launch, tapped per edge direction.
    logic [15:0] chain;
    int dRise = 0;
    int dFall = 0;
    bit stuck = 1'b0;
    logic tapRise, tapFall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[14:0], launch};
    end

    assign tapRise     = (dRise == 0) ? launch : chain[dRise-1];
    assign tapFall     = (dFall == 0) ? launch : chain[dFall-1];
    assign path_result = stuck ? 1'b0 : (launch ? tapRise : tapFall);

    int nChecks = 0;
    int nBad = 0;
    logic modelLaunch = 1'b0;
    logic [SUM_W-1:0] expQ[$];

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkEq({tag, "_busy"}, busy, 0);
        checkEq({tag, "_launch"}, launch, 0);
        checkEq({tag, "_valid"}, result_valid, 0);
        checkEq({tag, "_timeout"}, timeout, 0);
        checkEq({tag, "_sum"}, delay_sum, 0);
        checkEq({tag, "_avg"}, delay_avg, 0);
        checkEq({tag, "_trials"}, trials_done, 0);
`ifdef PATH_DELAY_MINMAX_EN
        checkEq({tag, "_min"}, delay_min, ALL1);
        checkEq({tag, "_max"}, delay_max, 0);
`endif
    endtask

    // One full measurement; hold > 0 keeps result_ready low that many cycles with a start pulse inside.
    task automatic runMeas(input int dr, input int df, input bit stk, input int hold);
        int expSum = 0;
        int expN = 0;
        int expMin = ALL1;
        int expMax = 0;
        bit expTo = 1'b0;
        logic lvl;
        int c;
        int cyc;
        lvl = modelLaunch;
        for (int t = 0; t < NT; t++) begin
            lvl = ~lvl;
            if (stk && lvl) begin
                expTo = 1'b1;
                break;
            end
            c = (lvl ? dr : df) + 2;
            expSum += c;
            expN++;
            if (c < expMin) expMin = c;
            if (c > expMax) expMax = c;
        end
        expQ.push_back(SUM_W'(expSum));

        dRise = dr;
        dFall = df;
        stuck = stk;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkEq("busy_after_start", busy, 1);

        cyc = 0;
        while (!result_valid && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checkEq("valid_in_time", result_valid, 1);
        checkEq("delay_sum", delay_sum, expQ.pop_front());
        checkEq("delay_avg", delay_avg, expSum >> TL);
        checkEq("trials_done", trials_done, expN);
        checkEq("timeout", timeout, expTo);
        checkEq("launch_level", launch, lvl);
`ifdef PATH_DELAY_MINMAX_EN
        checkEq("delay_min", delay_min, expMin);
        checkEq("delay_max", delay_max, expMax);
`endif

        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                start = (i == hold / 2);
                @(negedge clk);
            end
            start = 1'b0;
            checkEq("hold_valid", result_valid, 1);
            checkEq("hold_busy", busy, 1);
            checkEq("hold_sum", delay_sum, expSum);
            checkEq("hold_trials", trials_done, expN);
            checkEq("hold_launch", launch, lvl);
        end

        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        checkEq("idle_valid", result_valid, 0);
        checkEq("idle_busy", busy, 0);
        checkEq("idle_sum_held", delay_sum, expSum);
        checkEq("idle_timeout_held", timeout, expTo);
        modelLaunch = lvl;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        logic prevL;
        int tog;
        int cyc;

        #2;
        checkResetValues("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        runMeas(0, 0, 1'b0, 0);
        runMeas(5, 5, 1'b0, 0);
        runMeas(3, 6, 1'b0, 0);
        runMeas(2, 4, 1'b0, 50);
        for (int k = 0; k < 6; k++) begin
            runMeas($urandom_range(0, 10), $urandom_range(0, 10), 1'b0, $urandom_range(0, 3));
        end

        // Reset asserted in the middle of the third trial.
        dRise = 6;
        dFall = 6;
        stuck = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prevL = launch;
        tog = 1;
        cyc = 0;
        while (tog < 3 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (launch != prevL) begin
                tog++;
                prevL = launch;
            end
        end
        checkEq("third_trial_reached", tog, 3);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        modelLaunch = 1'b0;
        repeat (3) @(negedge clk);
        runMeas(2, 7, 1'b0, 0);

        runMeas(0, 0, 1'b1, 0);
        runMeas(4, 1, 1'b0, 0);
        runMeas($urandom_range(0, 10), $urandom_range(0, 10), 1'b0, 10);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
